// File: rtl/two_seq_pkg.sv
// Shared constants for the two-sequence transmitter: pattern values,
// FSM state encoding and counter widths.
package two_seq_pkg;

  localparam logic [3:0] PAT_0110 = 4'b0110;
  localparam logic [3:0] PAT_0111 = 4'b0111;

  localparam int GAP_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic [3:0] pattern_of(input logic sel);
    return sel ? PAT_0111 : PAT_0110;
  endfunction

endpackage

// File: rtl/seq_shift4.sv
// 4-bit parallel-load shift register, MSB out first; zeros shift in so the
// serial output falls to 0 once the pattern has been fully emitted.
module seq_shift4 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] load_val,
  output logic       dout
);

  logic [3:0] sreg_q;
  logic [3:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = load_val;
    end else if (shift) begin
      sreg_d = {sreg_q[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q <= 4'b0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign dout = sreg_q[3];

endmodule

// File: rtl/two_seq_gen.sv
// Serial pattern transmitter: sends 0110 or 0111 MSB-first, repeated count
// times with GAP idle cycles between repetitions, then pulses done.
module two_seq_gen
  import two_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             sel,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_e                 state_q, state_d;
  logic [1:0]             bit_idx_q, bit_idx_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic                   sel_q, sel_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   done_q, done_d;
  logic                   sh_load, sh_shift;
  logic [3:0]             sh_val;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    rem_d     = rem_q;
    sel_d     = sel_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_val    = 4'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_valid && !abort) begin
          sel_d     = sel;
          rem_d     = count;
          bit_idx_d = 2'd0;
          if (count != '0) begin
            state_d = ST_SEND;
            sh_load = 1'b1;
            sh_val  = pattern_of(sel);
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND: begin
        sh_shift  = 1'b1;
        bit_idx_d = bit_idx_q + 2'd1;
        if (bit_idx_q == 2'd3) begin
          // rem_q is never 0 here; the guard keeps the counter from wrapping
          rem_d = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
          if (rem_q <= CNT_W'(1)) begin
            state_d = ST_FIN;
          end else if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_INIT;
          end else begin
            sh_load = 1'b1;
            sh_val  = pattern_of(sel_q);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d   = ST_SEND;
          bit_idx_d = 2'd0;
          sh_load   = 1'b1;
          sh_val    = pattern_of(sel_q);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including the final bit, and flushes the shifter
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sh_load = 1'b1;
      sh_val  = 4'b0;
    end
  end

  assign dout_valid_d = (state_d == ST_SEND);
  assign done_d       = (state_d == ST_FIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= 2'd0;
      gap_cnt_q    <= '0;
      rem_q        <= '0;
      sel_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      rem_q        <= rem_d;
      sel_q        <= sel_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
    end
  end

  seq_shift4 u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .dout     (dout)
  );

  assign dout_valid  = dout_valid_q;
  assign done        = done_q;
  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_two_seq_gen.sv
// Scoreboard bench for two_seq_gen: requests push a cycle-stamped expected
// output stream; a negedge monitor pops and compares whatever the DUT emits.
module tb_two_seq_gen;

  localparam int CNT_W  = 4;
  localparam int TB_GAP = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_valid;
  logic             start_ready;
  logic             sel;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  two_seq_gen #(.CNT_W(CNT_W), .GAP(TB_GAP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sel         (sel),
    .count       (count),
    .abort       (abort),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic dout;
    logic done;
  } exp_t;

  exp_t q[$];
  int   busy_from = 0;
  int   busy_to   = 0;
  int   checks    = 0;
  int   errors    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_dout_valid"}, int'(dout_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_start_ready"}, int'(start_ready), 1);
  endtask

  // Monitor: busy/ready against the model window, outputs against the queue
  exp_t mon_e;
  logic mon_busy;
  always @(negedge clk) begin
    if (reset_n) begin
      mon_busy = (cyc >= busy_from) && (cyc < busy_to);
      chk("busy", int'(busy), int'(mon_busy));
      chk("start_ready", int'(start_ready), int'(!mon_busy));
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_output_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (dout_valid || done) begin
        if (q.size() == 0) begin
          chk("unexpected_output", int'({dout_valid, done}), 0);
        end else begin
          mon_e = q.pop_front();
          chk("output_cycle", cyc, mon_e.cyc);
          chk("dout_valid", int'(dout_valid), int'(!mon_e.done));
          chk("dout", int'(dout), int'(mon_e.dout));
          chk("done", int'(done), int'(mon_e.done));
        end
      end
      if (!dout_valid) chk("dout_zero_when_invalid", int'(dout), 0);
    end
  end

  task automatic flush_from(input int lim);
    while (q.size() > 0 && q[$].cyc >= lim) void'(q.pop_back());
  endtask

  // abort_k / rst_k: offset (cycles after first bit) at which to abort or reset; -1 = never
  task automatic run_req(input logic s, input int cnt, input int abort_k, input int rst_k);
    int   n;
    int   k;
    int   pat;
    exp_t e;
    while (cyc < busy_to) begin
      @(posedge clk); #1;
    end
    sel         = s;
    count       = CNT_W'(cnt);
    abort       = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    n   = cyc;
    pat = s ? 7 : 6;
    k   = 0;
    for (int r = 0; r < cnt; r++) begin
      for (int b = 3; b >= 0; b--) begin
        e.cyc = n + k; e.dout = 1'((pat >> b) & 1); e.done = 1'b0;
        q.push_back(e);
        k++;
      end
      if (r < cnt - 1) k += TB_GAP;
    end
    e.cyc = n + k; e.dout = 1'b0; e.done = 1'b1;
    q.push_back(e);
    busy_from = n;
    busy_to   = n + k + 1;
    while (1) begin
      if (cyc >= busy_to) break;
      if (rst_k >= 0 && cyc == n + rst_k) begin
        start_valid = 1'b0;
        abort       = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        busy_to = cyc;
        chk_reset_outputs("async_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        break;
      end
      start_valid = ($urandom_range(0, 2) == 0);
      sel         = 1'($urandom_range(0, 1));
      count       = CNT_W'($urandom_range(0, 15));
      if (abort_k >= 0 && cyc == n + abort_k) begin
        abort = 1'b1;
        flush_from(cyc + 1);
        busy_to = cyc + 1;
      end else begin
        abort = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    abort       = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    start_valid = 1'b0;
    sel         = 1'b0;
    count       = '0;
    abort       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_req(1'b0, 1, -1, -1);
    run_req(1'b1, 3, -1, -1);
    run_req(1'b0, 0, -1, -1);
    run_req(1'b1, 3, 4 + TB_GAP + 1, -1);
    run_req(1'b0, 2, 4 + TB_GAP + 3, -1);
    run_req(1'b1, 15, -1, -1);

    // start together with abort in IDLE must not be accepted
    start_valid = 1'b1;
    abort       = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    abort       = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    run_req(1'b1, 2, -1, 5);
    run_req(1'b0, 1, -1, -1);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_req(1'($urandom_range(0, 1)), $urandom_range(0, 15),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1, -1);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
